// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: access-mode encodings, FSM states and
// decode helpers used by the LSU, the data memory decode and the control unit.
package lsu_pkg;

  localparam int unsigned LSU_DW = 32;

  // AddrMode encodings; any value with bit 3 set is a NOP.
  typedef enum logic [3:0] {
    AM_LB  = 4'b0000,
    AM_LH  = 4'b0001,
    AM_LW  = 4'b0010,
    AM_LBU = 4'b0011,
    AM_LHU = 4'b0100,
    AM_SB  = 4'b0101,
    AM_SH  = 4'b0110,
    AM_SW  = 4'b0111,
    AM_NOP = 4'b1000
  } addr_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    RESP
  } lsu_state_e;

  // Access size in bytes; 0 for NOP.
  function automatic logic [2:0] size_of(input addr_mode_e mode);
    case (mode)
      AM_LB, AM_LBU, AM_SB: size_of = 3'd1;
      AM_LH, AM_LHU, AM_SH: size_of = 3'd2;
      AM_LW, AM_SW:         size_of = 3'd4;
      default:              size_of = 3'd0;
    endcase
  endfunction

  function automatic logic is_store(input addr_mode_e mode);
    is_store = (mode inside {AM_SB, AM_SH, AM_SW});
  endfunction

  function automatic logic is_load(input addr_mode_e mode);
    is_load = (mode inside {AM_LB, AM_LH, AM_LW, AM_LBU, AM_LHU});
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: positions store data/strobes across a
// two-word window and extracts/extends load data from the beat buffer.
module lsu_align
  import lsu_pkg::*;
(
  input  addr_mode_e                st_mode,
  input  logic [1:0]                st_off,
  input  logic [LSU_DW-1:0]         st_wd,
  output logic [LSU_DW-1:0]         st_wdata_lo,
  output logic [LSU_DW-1:0]         st_wdata_hi,
  output logic [3:0]                st_strb_lo,
  output logic [3:0]                st_strb_hi,
  input  addr_mode_e                ld_mode,
  input  logic [1:0]                ld_off,
  input  logic [2*LSU_DW-1:0]       ld_buf,
  output logic [LSU_DW-1:0]         ld_data
);

  logic [3:0]          mask;
  logic [2*LSU_DW-1:0] wd64;
  logic [7:0]          st64;
  logic [LSU_DW-1:0]   x;

  // Store path: shift data and byte mask to the addressed lanes; loads/NOPs drive zeros.
  always_comb begin
    case (st_mode)
      AM_SB:   mask = 4'b0001;
      AM_SH:   mask = 4'b0011;
      AM_SW:   mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    wd64 = {{LSU_DW{1'b0}}, st_wd} << {st_off, 3'b000};
    st64 = {4'b0000, mask} << st_off;
    if (is_store(st_mode)) begin
      st_wdata_lo = wd64[LSU_DW-1:0];
      st_wdata_hi = wd64[2*LSU_DW-1:LSU_DW];
      st_strb_lo  = st64[3:0];
      st_strb_hi  = st64[7:4];
    end else begin
      st_wdata_lo = '0;
      st_wdata_hi = '0;
      st_strb_lo  = '0;
      st_strb_hi  = '0;
    end
  end

  // Load path: shift the addressed byte down to lane 0, then extend per mode.
  always_comb begin
    x = LSU_DW'(ld_buf >> {ld_off, 3'b000});
    case (ld_mode)
      AM_LB:   ld_data = {{24{x[7]}}, x[7:0]};
      AM_LH:   ld_data = {{16{x[15]}}, x[15:0]};
      AM_LBU:  ld_data = {24'b0, x[7:0]};
      AM_LHU:  ld_data = {16'b0, x[15:0]};
      AM_LW:   ld_data = x;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// CPU-side data memory initiator: accepts one load/store per handshake,
// issues one or two word-aligned bus beats, and returns extended load data.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            AddrMode,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] WD,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  resp_valid,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_e              state, state_nxt;
  addr_mode_e              mode_in, mode_q;
  logic [1:0]              off_q;
  logic                    split_in, split_q;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   wdata_lo, wdata_hi, wdata_hi_q;
  logic [3:0]              strb_lo, strb_hi, wstrb_hi_q;
  logic [2*DATA_WIDTH-1:0] beat_buf;
  logic [DATA_WIDTH-1:0]   ld_data;

  // Decode the live request: fold every 1xxx encoding onto NOP and flag straddling accesses.
  always_comb begin
    mode_in  = AddrMode[3] ? AM_NOP : addr_mode_e'(AddrMode);
    split_in = ({2'b00, A[1:0]} + {1'b0, size_of(mode_in)}) > 4'd4;
    accept   = req_valid && (state == IDLE);
  end

  lsu_align u_align (
    .st_mode     (mode_in),
    .st_off      (A[1:0]),
    .st_wd       (WD),
    .st_wdata_lo (wdata_lo),
    .st_wdata_hi (wdata_hi),
    .st_strb_lo  (strb_lo),
    .st_strb_hi  (strb_hi),
    .ld_mode     (mode_q),
    .ld_off      (off_q),
    .ld_buf      (beat_buf),
    .ld_data     (ld_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = AddrMode[3] ? RESP : BEAT0;
      BEAT0:   if (mem_ready) state_nxt = split_q ? BEAT1 : RESP;
      BEAT1:   if (mem_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; req_ready is qualified by rst_n so every output reads 0 during reset.
  always_comb begin
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    resp_valid = 1'b0;
    RD         = '0;
    case (state)
      IDLE:         req_ready = rst_n;
      BEAT0, BEAT1: mem_req = 1'b1;
      RESP: begin
        resp_valid = 1'b1;
        if (is_load(mode_q)) RD = ld_data;
      end
      default: ;
    endcase
  end

  // Op latches, registered bus fields and beat buffer; bus fields return to 0 after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= AM_NOP;
      off_q      <= '0;
      split_q    <= 1'b0;
      wdata_hi_q <= '0;
      wstrb_hi_q <= '0;
      beat_buf   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mode_q   <= mode_in;
            off_q    <= A[1:0];
            split_q  <= split_in;
            beat_buf <= '0;
            if (!AddrMode[3]) begin
              mem_addr   <= {A[ADDR_WIDTH-1:2], 2'b00};
              mem_we     <= is_store(mode_in);
              mem_wdata  <= wdata_lo;
              mem_wstrb  <= strb_lo;
              wdata_hi_q <= wdata_hi;
              wstrb_hi_q <= strb_hi;
            end
          end
        end
        BEAT0: begin
          if (mem_ready) begin
            beat_buf[DATA_WIDTH-1:0] <= mem_rdata;
            if (split_q) begin
              mem_addr  <= mem_addr + ADDR_WIDTH'(4);
              mem_wdata <= wdata_hi_q;
              mem_wstrb <= wstrb_hi_q;
            end else begin
              mem_addr  <= '0;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
              mem_wstrb <= '0;
            end
          end
        end
        BEAT1: begin
          if (mem_ready) begin
            beat_buf[2*DATA_WIDTH-1:DATA_WIDTH] <= mem_rdata;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Scoreboard bench for lsu_mem_if: each test queues expected bus beats and
// responses, a bus responder records what the DUT does, and the test compares.
module tb_lsu_mem_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  AddrMode;
  logic [31:0] A, WD, RD;
  logic        resp_valid, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;

  lsu_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .AddrMode(AddrMode), .A(A), .WD(WD), .RD(RD), .resp_valid(resp_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } beat_t;

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] lat;
  } resp_t;

  beat_t       exp_beat_q[$], obs_beat_q[$];
  resp_t       exp_resp_q[$];
  logic [31:0] rdata_q[$];
  resp_t       obs_resp;
  logic        obs_hold_ok, obs_busy_ok, obs_accept_ready, obs_resp_after;
  logic        stray_ready = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  // Drive one op and act as the memory; waits stall the first beat.
  task automatic run_op(input logic [3:0] mode, input logic [31:0] addr,
                        input logic [31:0] wd, input int waits);
    beat_t cur;
    bit    in_beat;
    int    wl;
    wl = waits; in_beat = 0;
    obs_hold_ok = 1'b1; obs_busy_ok = 1'b1;
    obs_resp = '{rd: 32'hxxxxxxxx, lat: 32'hFFFFFFFF};
    @(negedge clk);
    obs_accept_ready = req_ready;
    req_valid = 1'b1; AddrMode = mode; A = addr; WD = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; AddrMode = 4'($urandom); A = $urandom; WD = $urandom;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (req_ready !== 1'b0) obs_busy_ok = 1'b0;
      if (resp_valid === 1'b1) begin
        obs_resp = '{rd: RD, lat: 32'(cyc)};
        mem_ready = 1'b0;
        break;
      end
      if (mem_req === 1'b1) begin
        if (!in_beat) begin
          cur = {mem_addr, mem_we, mem_wdata, mem_wstrb};
          in_beat = 1;
        end else if ({mem_addr, mem_we, mem_wdata, mem_wstrb} !== cur) begin
          obs_hold_ok = 1'b0;
        end
        if (wl > 0) begin
          mem_ready = 1'b0; mem_rdata = $urandom; wl--;
        end else begin
          mem_ready = 1'b1;
          mem_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : $urandom;
          obs_beat_q.push_back(cur);
          in_beat = 0;
        end
      end else begin
        mem_ready = stray_ready; mem_rdata = $urandom;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    @(negedge clk);
    obs_resp_after = resp_valid;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({req_ready, resp_valid, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, RD} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rr=%b rv=%b req=%b we=%b strb=%h addr=%h wdata=%h rd=%h required all 0",
               req_ready, resp_valid, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, RD);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready: got %b required 1", req_ready);
    end
  endtask

  // Scoreboard drain shared pattern, written out per test for its own names.
  task automatic test_store_aligned();
    beat_t eb, ob; resp_t er;
    exp_beat_q.push_back({32'h1000, 1'b1, 32'hDEADBEEF, 4'b1111});
    exp_resp_q.push_back('{rd: 32'h0, lat: 32'd2});
    run_op(4'b0111, 32'h1000, 32'hDEADBEEF, 0);
    vectors++;
    if (obs_accept_ready !== 1'b1) begin miscompares++; $display("FAIL sw_ready: got %b required 1", obs_accept_ready); end
    while (exp_beat_q.size() > 0) begin
      eb = exp_beat_q.pop_front(); vectors++;
      ob = (obs_beat_q.size() > 0) ? obs_beat_q.pop_front() : 'x;
      if (ob !== eb) begin miscompares++; $display("FAIL sw_beat: got %h required %h", ob, eb); end
    end
    er = exp_resp_q.pop_front(); vectors++;
    if (obs_resp !== er) begin miscompares++; $display("FAIL sw_resp: got rd=%h lat=%0d required rd=%h lat=%0d", obs_resp.rd, obs_resp.lat, er.rd, er.lat); end
    vectors++;
    if (obs_resp_after !== 1'b0) begin miscompares++; $display("FAIL sw_pulse: got resp_valid %b after pulse required 0", obs_resp_after); end
  endtask

  task automatic test_byte_lanes();
    beat_t eb, ob; resp_t er;
    exp_beat_q.push_back({32'h1000, 1'b1, 32'hAB000000, 4'b1000});
    exp_resp_q.push_back('{rd: 32'h0, lat: 32'd2});
    run_op(4'b0101, 32'h1003, 32'h000000AB, 0);
    exp_beat_q.push_back({32'h1000, 1'b0, 32'h0, 4'b0000});
    exp_resp_q.push_back('{rd: 32'hFFFFFFAB, lat: 32'd2});
    rdata_q.push_back(32'hAB000000);
    run_op(4'b0000, 32'h1003, 32'h0, 0);
    while (exp_beat_q.size() > 0) begin
      eb = exp_beat_q.pop_front(); vectors++;
      ob = (obs_beat_q.size() > 0) ? obs_beat_q.pop_front() : 'x;
      if (ob !== eb) begin miscompares++; $display("FAIL lane_beat: got %h required %h", ob, eb); end
    end
    while (exp_resp_q.size() > 0) begin
      er = exp_resp_q.pop_front(); vectors++;
      if (er.rd == 32'hFFFFFFAB && obs_resp !== er) begin
        miscompares++; $display("FAIL lb_resp: got rd=%h lat=%0d required rd=%h lat=%0d", obs_resp.rd, obs_resp.lat, er.rd, er.lat);
      end
    end
  endtask

  task automatic test_split();
    beat_t eb, ob; resp_t er;
    exp_beat_q.push_back({32'h1000, 1'b0, 32'h0, 4'b0000});
    exp_beat_q.push_back({32'h1004, 1'b0, 32'h0, 4'b0000});
    er = '{rd: 32'h00001234, lat: 32'd3};
    rdata_q.push_back(32'h345A5A5A);
    rdata_q.push_back(32'hA5A5A512);
    run_op(4'b0100, 32'h1003, 32'h0, 0);
    vectors++;
    if (obs_resp !== er) begin miscompares++; $display("FAIL lhu_split_resp: got rd=%h lat=%0d required rd=%h lat=%0d", obs_resp.rd, obs_resp.lat, er.rd, er.lat); end
    exp_beat_q.push_back({32'hFFFFFFFC, 1'b1, 32'h33440000, 4'b1100});
    exp_beat_q.push_back({32'h00000000, 1'b1, 32'h00001122, 4'b0011});
    er = '{rd: 32'h0, lat: 32'd3};
    run_op(4'b0111, 32'hFFFFFFFE, 32'h11223344, 0);
    vectors++;
    if (obs_resp !== er) begin miscompares++; $display("FAIL sw_wrap_resp: got rd=%h lat=%0d required rd=%h lat=%0d", obs_resp.rd, obs_resp.lat, er.rd, er.lat); end
    while (exp_beat_q.size() > 0) begin
      eb = exp_beat_q.pop_front(); vectors++;
      ob = (obs_beat_q.size() > 0) ? obs_beat_q.pop_front() : 'x;
      if (ob !== eb) begin miscompares++; $display("FAIL split_beat: got %h required %h", ob, eb); end
    end
  endtask

  task automatic test_wait_states();
    beat_t eb, ob; resp_t er;
    exp_beat_q.push_back({32'h2000, 1'b0, 32'h0, 4'b0000});
    er = '{rd: 32'h89ABCDEF, lat: 32'd5};
    rdata_q.push_back(32'h89ABCDEF);
    run_op(4'b0010, 32'h2000, 32'h0, 3);
    eb = exp_beat_q.pop_front(); vectors++;
    ob = (obs_beat_q.size() > 0) ? obs_beat_q.pop_front() : 'x;
    if (ob !== eb) begin miscompares++; $display("FAIL wait_beat: got %h required %h", ob, eb); end
    vectors++;
    if (obs_resp !== er) begin miscompares++; $display("FAIL wait_resp: got rd=%h lat=%0d required rd=%h lat=%0d", obs_resp.rd, obs_resp.lat, er.rd, er.lat); end
    vectors++;
    if (obs_hold_ok !== 1'b1) begin miscompares++; $display("FAIL wait_hold: got stable=%b required 1", obs_hold_ok); end
    vectors++;
    if (obs_busy_ok !== 1'b1) begin miscompares++; $display("FAIL wait_ready_low: got ok=%b required 1", obs_busy_ok); end
  endtask

  // Back-to-back random ops checked against a byte-level reference model.
  task automatic test_back_to_back();
    beat_t eb, ob; resp_t er;
    logic [3:0]  mode, mask;
    logic [31:0] addr, wd, w0, w1, x;
    logic [63:0] wd64, win;
    logic [7:0]  st8;
    int          off, size;
    bit          st, split;
    for (int n = 0; n < 16; n++) begin
      mode = 4'($urandom_range(0, 7)); addr = $urandom; wd = $urandom;
      w0 = $urandom; w1 = $urandom;
      off = int'(addr[1:0]);
      size = (mode == 4'd2 || mode == 4'd7) ? 4 :
             (mode == 4'd1 || mode == 4'd4 || mode == 4'd6) ? 2 : 1;
      mask = (size == 4) ? 4'b1111 : (size == 2) ? 4'b0011 : 4'b0001;
      st = (mode >= 4'd5);
      split = (off + size) > 4;
      wd64 = {32'b0, wd} << (8 * off);
      st8 = {4'b0, mask} << off;
      exp_beat_q.push_back({addr & 32'hFFFFFFFC, st, st ? wd64[31:0] : 32'h0, st ? st8[3:0] : 4'h0});
      if (split) exp_beat_q.push_back({(addr & 32'hFFFFFFFC) + 32'd4, st, st ? wd64[63:32] : 32'h0, st ? st8[7:4] : 4'h0});
      win = {w1, w0} >> (8 * off);
      x = win[31:0];
      case (mode)
        4'd0:    er.rd = {{24{x[7]}}, x[7:0]};
        4'd1:    er.rd = {{16{x[15]}}, x[15:0]};
        4'd2:    er.rd = x;
        4'd3:    er.rd = {24'b0, x[7:0]};
        4'd4:    er.rd = {16'b0, x[15:0]};
        default: er.rd = 32'h0;
      endcase
      er.lat = split ? 32'd3 : 32'd2;
      exp_resp_q.push_back(er);
      rdata_q.push_back(w0);
      if (split) rdata_q.push_back(w1);
      run_op(mode, addr, wd, n % 3);
      if (!split) er.lat = er.lat + 32'(n % 3);
      else        er.lat = er.lat + 32'(n % 3);
      void'(exp_resp_q.pop_front());
      vectors++;
      if (obs_resp !== er) begin
        miscompares++;
        $display("FAIL rand_resp[%0d] mode=%h A=%h: got rd=%h lat=%0d required rd=%h lat=%0d",
                 n, mode, addr, obs_resp.rd, obs_resp.lat, er.rd, er.lat);
      end
      while (exp_beat_q.size() > 0) begin
        eb = exp_beat_q.pop_front(); vectors++;
        ob = (obs_beat_q.size() > 0) ? obs_beat_q.pop_front() : 'x;
        if (ob !== eb) begin miscompares++; $display("FAIL rand_beat[%0d]: got %h required %h", n, ob, eb); end
      end
      vectors++;
      if (obs_beat_q.size() != 0) begin
        miscompares++; $display("FAIL rand_extra_beats[%0d]: got %0d required 0", n, obs_beat_q.size());
        obs_beat_q.delete();
      end
      rdata_q.delete();
    end
  endtask

  task automatic test_reset_mid_op();
    resp_t er;
    @(negedge clk);
    req_valid = 1'b1; AddrMode = 4'b0100; A = 32'h1003; WD = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h34000000;
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    vectors++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h1004}) begin
      miscompares++; $display("FAIL rst_in_beat1: got req=%b addr=%h required req=1 addr=00001004", mem_req, mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_req, resp_valid, RD, mem_wstrb, req_ready} !== '0) begin
      miscompares++; $display("FAIL rst_abort: got req=%b rv=%b rd=%h strb=%h rr=%b required all 0",
                              mem_req, resp_valid, RD, mem_wstrb, req_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    stray_ready = 1'b1;
    er = '{rd: 32'h0, lat: 32'd1};
    run_op(4'b1000, 32'h1234, 32'hFFFFFFFF, 0);
    stray_ready = 1'b0;
    vectors++;
    if (obs_resp !== er) begin miscompares++; $display("FAIL nop_resp: got rd=%h lat=%0d required rd=%h lat=%0d", obs_resp.rd, obs_resp.lat, er.rd, er.lat); end
    vectors++;
    if (obs_beat_q.size() != 0) begin
      miscompares++; $display("FAIL nop_no_bus: got %0d beats required 0", obs_beat_q.size());
      obs_beat_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; AddrMode = 4'b1000; A = '0; WD = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    test_reset();
    test_store_aligned();
    test_byte_lanes();
    test_split();
    test_wait_states();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
